// File: rtl/ysyx_23060124_ifu_idu_regs.sv
// IFU->IDU pipeline register: two-entry skid buffer (head H + skid S) carrying
// {pc, inst, fault}, with single-cycle flush and a saturating dequeue counter.
module ysyx_23060124_ifu_idu_regs #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_pre_valid,
  output logic             o_pre_ready,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_inst,
  input  logic             i_fault,
  input  logic             i_flush,
  output logic             o_post_valid,
  input  logic             i_post_ready,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_inst,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_fetch_cnt
);

  localparam logic [CNT_W-1:0] FC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_cnt;
  logic [31:0]      r_h_pc, r_h_inst, r_s_pc, r_s_inst;
  logic             r_h_fault, r_s_fault;
  logic [CNT_W-1:0] r_fc;
  logic             w_acc, w_deq;

  // Handshake flags come only from r_cnt, so ready never depends on i_post_ready.
  assign o_post_valid = (r_cnt != 2'd0);
  assign o_pre_ready  = (r_cnt != 2'd2);
  assign o_pc         = r_h_pc;
  assign o_inst       = r_h_inst;
  assign o_fault      = r_h_fault;
  assign o_fetch_cnt  = r_fc;

  assign w_acc = i_pre_valid & o_pre_ready & ~i_flush;
  assign w_deq = o_post_valid & i_post_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt     <= 2'd0;
      r_h_pc    <= '0;
      r_h_inst  <= '0;
      r_h_fault <= 1'b0;
      r_s_pc    <= '0;
      r_s_inst  <= '0;
      r_s_fault <= 1'b0;
      r_fc      <= '0;
    end else begin
      // A dequeue coincident with flush still counts: IDU already took the head.
      if (w_deq && r_fc != {CNT_W{1'b1}}) r_fc <= r_fc + FC_ONE;
      if (i_flush) begin
        r_cnt     <= 2'd0;
        r_h_pc    <= '0;
        r_h_inst  <= '0;
        r_h_fault <= 1'b0;
        r_s_pc    <= '0;
        r_s_inst  <= '0;
        r_s_fault <= 1'b0;
      end else begin
        case (r_cnt)
          2'd0: begin
            if (w_acc) begin
              r_h_pc    <= i_pc;
              r_h_inst  <= i_inst;
              r_h_fault <= i_fault;
              r_cnt     <= 2'd1;
            end
          end
          2'd1: begin
            if (w_acc && w_deq) begin
              r_h_pc    <= i_pc;
              r_h_inst  <= i_inst;
              r_h_fault <= i_fault;
            end else if (w_acc) begin
              r_s_pc    <= i_pc;
              r_s_inst  <= i_inst;
              r_s_fault <= i_fault;
              r_cnt     <= 2'd2;
            end else if (w_deq) begin
              r_h_pc    <= '0;
              r_h_inst  <= '0;
              r_h_fault <= 1'b0;
              r_cnt     <= 2'd0;
            end
          end
          default: begin
            if (w_deq) begin
              r_h_pc    <= r_s_pc;
              r_h_inst  <= r_s_inst;
              r_h_fault <= r_s_fault;
              r_s_pc    <= '0;
              r_s_inst  <= '0;
              r_s_fault <= 1'b0;
              r_cnt     <= 2'd1;
            end
          end
        endcase
      end
    end
  end

endmodule
